mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the multicycle 8-bit MIPS core. It serves the
//   byte-wide read and write requests the controller issues (memread,
//   memwrite, iord-muxed adr), including the four byte fetches that fill
//   irwrite[3:0].
//   Holds a single-port byte RAM and a wait-state FSM. memready is the stall
//   handshake: the core must not advance its state until memready is seen.
// PARAMETERS
//   WIDTH        8   data byte width (bits)
//   ADDR_W       8   address width; RAM depth = 2**ADDR_W bytes
//   WAIT_STATES  1   extra cycles inserted before memready (0..15)
//   PROT_LIMIT   64  first writable address (used only with MEMRESP_PROTECT_EN)
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-low reset (0 = in reset)
//   memread    in   1       read request from controller
//   memwrite   in   1       write request from controller
//   adr        in   ADDR_W  byte address (PC or ALUOut, muxed by iord)
//   writedata  in   WIDTH   write data byte
//   memdata    out  WIDTH   read data byte; valid when memready=1 on a read
//   memready   out  1       one-cycle completion pulse
//   prot_err   out  1       write-protect violation pulse (MEMRESP_PROTECT_EN only)
// BEHAVIOUR
//   - Reset values: state=IDLE, memdata=0, memready=0, prot_err=0, wcnt=0.
//     RAM contents are not cleared.
//   - FSM states: IDLE, BUSY, DONE. All outputs are registered.
//   - IDLE: when memread|memwrite=1 at a clock edge, the block latches adr,
//     writedata and op. Next state is BUSY with wcnt=WAIT_STATES-1, or DONE
//     if WAIT_STATES=0.
//   - BUSY: wcnt decrements each cycle. At wcnt=0 the FSM goes to DONE.
//     Request inputs are ignored while in BUSY.
//   - DONE: memready=1 for exactly one cycle, then the FSM returns to IDLE.
//     A read loads memdata=RAM[adr_q] on the edge that enters DONE.
//     A write commits RAM[adr_q]=wdata_q on the same edge.
//   - Latency: memready is high in cycle N+WAIT_STATES+1 when the request is
//     sampled at edge N. Minimum turnaround is WAIT_STATES+2 cycles per
//     access, because one IDLE cycle follows each DONE.
//   - The core holds memread/memwrite/adr/writedata stable until it sees
//     memready. A request still asserted in DONE is not re-sampled. The next
//     request is sampled in the following IDLE cycle.
//   - memread=memwrite=1 together: the write has priority and no read
//     occurs; memdata keeps its previous value.
//   - memdata holds the last read value until the next read completes. It is
//     unchanged by writes.
//   - Address is always in range (depth = 2**ADDR_W). No wrap logic needed.
//   - Reset asserted mid-operation: immediately returns to IDLE with
//     memready=0. A pending write is discarded and RAM is untouched.
// CONFIGURATION
//   MEMRESP_PROTECT_EN defined: a write with adr_q < PROT_LIMIT does not
//     modify RAM, still completes with memready=1, and pulses prot_err=1 in
//     the same DONE cycle.
//   Undefined: every address is writable and prot_err is tied to 0.
// TESTING
//   1. WAIT_STATES=1: write 0x5A@0x10 sampled at edge 0 -> memready high in
//      cycle 2. Read 0x10 -> memdata=0x5A with memready.
//   2. WAIT_STATES=0: preload 0x00..0x03 = 0x20,0x08,0x00,0x01; four
//      back-to-back fetch reads -> bytes returned in order, memready every
//      2nd cycle.
//   3. memread=memwrite=1, adr=0x40, wd=0xC3 -> RAM[0x40]=0xC3 and memdata
//      unchanged. A later read of 0x40 returns 0xC3.
//   4. WAIT_STATES=3: drop reset low during BUSY of a write 0x77@0x50 ->
//      memready stays 0 and the FSM is IDLE. A read of 0x50 returns the old
//      contents.
//   5. MEMRESP_PROTECT_EN, PROT_LIMIT=64: write 0xFF@0x20 -> prot_err=1 and
//      memready=1, RAM[0x20] unchanged. Write 0xFF@0x40 -> prot_err=0 and
//      the value is stored.
//   6. Request held through DONE for 3 extra cycles -> exactly one memready
//      per IDLE sample (access repeats only from IDLE, never in DONE/BUSY).

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the multicycle 8-bit MIPS core.
// It holds a single-port byte RAM behind a wait-state FSM (IDLE -> BUSY -> DONE).
// One request is sampled in IDLE. memready is a registered one-cycle pulse.
// The core must hold its request until it sees memready.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (0 = in reset)
//   memread    read request
//   memwrite   write request (has priority when both are set)
//   adr        byte address
//   writedata  write data byte
//   memdata    read data byte, held until the next read completes
//   memready   one-cycle completion pulse
//   prot_err   write-protect violation pulse
//
// Optional feature: define MEMRESP_PROTECT_EN to block writes below
// PROT_LIMIT. Such writes still complete, with prot_err pulsed in the
// DONE cycle. Without the macro, prot_err is tied to 0.
module mem_responder #(
  parameter int WIDTH       = 8,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1,
  parameter int PROT_LIMIT  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] adr,
  input  logic [WIDTH-1:0]  writedata,
  output logic [WIDTH-1:0]  memdata,
  output logic              memready,
  output logic              prot_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] WCNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t            state, state_nxt;
  logic [3:0]        wcnt, wcnt_nxt;
  logic              alive;
  logic              accept, enter_done;
  logic [ADDR_W-1:0] adr_p0;
  logic [WIDTH-1:0]  wdata_p0;
  logic              wr_p0;
  logic [ADDR_W-1:0] eff_adr;
  logic [WIDTH-1:0]  eff_wdata;
  logic              eff_wr;
  logic              prot_hit;
  logic [WIDTH-1:0]  ram [2**ADDR_W];

  // With zero wait states DONE is entered on the sampling edge itself, so the
  // live request is used. Otherwise the latched copy is used.
  always_comb begin
    eff_adr   = adr_p0;
    eff_wdata = wdata_p0;
    eff_wr    = wr_p0;
    if (state == IDLE) begin
      eff_adr   = adr;
      eff_wdata = writedata;
      eff_wr    = memwrite;
    end
  end

  // Next-state logic. alive keeps the first edge after reset release from
  // sampling a request, so RAM cannot be written while reset is asserted.
  always_comb begin
    state_nxt  = state;
    wcnt_nxt   = wcnt;
    accept     = 1'b0;
    enter_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (alive && (memread || memwrite)) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_nxt  = DONE;
            enter_done = 1'b1;
          end else begin
            state_nxt = BUSY;
            wcnt_nxt  = WCNT_INIT;
          end
        end
      end
      BUSY: begin
        if (wcnt == 4'd0) begin
          state_nxt  = DONE;
          enter_done = 1'b1;
        end else begin
          wcnt_nxt = wcnt - 4'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEMRESP_PROTECT_EN
  localparam logic [ADDR_W:0] PROT_L = (ADDR_W + 1)'(PROT_LIMIT);
  assign prot_hit = ({1'b0, eff_adr} < PROT_L);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prot_err <= 1'b0;
    else        prot_err <= enter_done && eff_wr && prot_hit;
  end
`else
  assign prot_hit = 1'b0;
  assign prot_err = 1'b0;
`endif

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wcnt     <= 4'd0;
      alive    <= 1'b0;
      memready <= 1'b0;
      memdata  <= '0;
    end else begin
      state    <= state_nxt;
      wcnt     <= wcnt_nxt;
      alive    <= 1'b1;
      memready <= enter_done;
      if (enter_done && !eff_wr) memdata <= ram[eff_adr];
    end
  end

  // Request capture stage (_p0)
  always_ff @(posedge clk) begin
    if (accept) begin
      adr_p0   <= adr;
      wdata_p0 <= writedata;
      wr_p0    <= memwrite;
    end
  end

  // RAM commit on the edge entering DONE
  always_ff @(posedge clk) begin
    if (enter_done && eff_wr && !prot_hit) ram[eff_adr] <= eff_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

`ifdef MEMRESP_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n     [3];
  logic       memread   [3];
  logic       memwrite  [3];
  logic [7:0] adr       [3];
  logic [7:0] writedata [3];
  logic [7:0] memdata   [3];
  logic       memready  [3];
  logic       prot_err  [3];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: WAIT_STATES=0, instance 1: 1, instance 2: 3
  mem_responder #(.WIDTH(8), .ADDR_W(8), .WAIT_STATES(0), .PROT_LIMIT(64)) u0 (
    .clk(clk), .reset(rst_n[0]), .memread(memread[0]), .memwrite(memwrite[0]),
    .adr(adr[0]), .writedata(writedata[0]), .memdata(memdata[0]),
    .memready(memready[0]), .prot_err(prot_err[0]));
  mem_responder #(.WIDTH(8), .ADDR_W(8), .WAIT_STATES(1), .PROT_LIMIT(64)) u1 (
    .clk(clk), .reset(rst_n[1]), .memread(memread[1]), .memwrite(memwrite[1]),
    .adr(adr[1]), .writedata(writedata[1]), .memdata(memdata[1]),
    .memready(memready[1]), .prot_err(prot_err[1]));
  mem_responder #(.WIDTH(8), .ADDR_W(8), .WAIT_STATES(3), .PROT_LIMIT(64)) u2 (
    .clk(clk), .reset(rst_n[2]), .memread(memread[2]), .memwrite(memwrite[2]),
    .adr(adr[2]), .writedata(writedata[2]), .memdata(memdata[2]),
    .memready(memready[2]), .prot_err(prot_err[2]));

  function automatic int ws(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One access: drive, wait for memready, check latency, release, then check
  // that memready drops on the following edge (back in IDLE).
  task automatic access(input int i, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d,
                        output logic [7:0] q, output logic pe, output int t);
    int cnt;
    memread[i] = rd; memwrite[i] = wr; adr[i] = a; writedata[i] = d;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!memready[i] && cnt < 50);
    chk($sformatf("latency u%0d a=%0h", i, a), memready[i] ? cnt : -1, ws(i) + 1);
    q = memdata[i]; pe = prot_err[i]; t = cyc;
    memread[i] = 1'b0; memwrite[i] = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("pulse_end u%0d", i), int'(memready[i]), 0);
  endtask

  // Hold a read request for n edges and record the memready pattern.
  task automatic hold(input int i, input logic [7:0] a, input int n,
                      output logic [15:0] pat);
    pat = '0;
    memread[i] = 1'b1; memwrite[i] = 1'b0; adr[i] = a;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      pat[k] = memready[i];
    end
    memread[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;  // memdata expected with memready
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [7:0]  q, v0, base, t1a;
    logic        pe;
    int          t, tprev;
    logic [15:0] pat;
    logic [7:0]  fetch[4];

    tbl[0]  = '{1'b0, 1'b1, 8'h44, 8'h5A, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 8'h44, 8'h00, 8'h5A};
    tbl[2]  = '{1'b0, 1'b1, 8'h41, 8'hA5, 8'h5A};
    tbl[3]  = '{1'b1, 1'b0, 8'h41, 8'h00, 8'hA5};
    tbl[4]  = '{1'b1, 1'b1, 8'h40, 8'hC3, 8'hA5};  // write wins, memdata held
    tbl[5]  = '{1'b1, 1'b0, 8'h40, 8'h00, 8'hC3};
    tbl[6]  = '{1'b1, 1'b0, 8'h44, 8'h00, 8'h5A};
    tbl[7]  = '{1'b0, 1'b1, 8'hFF, 8'h3C, 8'h5A};
    tbl[8]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h3C};
    tbl[9]  = '{1'b0, 1'b1, 8'h44, 8'h00, 8'h3C};
    tbl[10] = '{1'b1, 1'b0, 8'h44, 8'h00, 8'h00};
    tbl[11] = '{1'b1, 1'b0, 8'h41, 8'h00, 8'hA5};

    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; memread[i] = 1'b0; memwrite[i] = 1'b0;
      adr[i] = 8'h00; writedata[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst memready u%0d", i), int'(memready[i]), 0);
      chk($sformatf("rst memdata u%0d", i), int'(memdata[i]), 0);
      chk($sformatf("rst prot_err u%0d", i), int'(prot_err[i]), 0);
      rst_n[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;

    // Table vectors on WAIT_STATES=1
    for (int v = 0; v < 12; v++) begin
      access(1, tbl[v].rd, tbl[v].wr, tbl[v].a, tbl[v].d, q, pe, t);
      chk($sformatf("vec%0d memdata", v), int'(q), int'(tbl[v].exp));
      chk($sformatf("vec%0d prot_err", v), int'(pe), 0);
    end

    // Write then read back on WAIT_STATES=1
    t1a = PROT ? 8'h50 : 8'h10;
    access(1, 1'b0, 1'b1, t1a, 8'h5A, q, pe, t);
    access(1, 1'b1, 1'b0, t1a, 8'h00, q, pe, t);
    chk("t1 readback", int'(q), 8'h5A);

    // Fetch sequence on WAIT_STATES=0, memready every second cycle
    base = PROT ? 8'h80 : 8'h00;
    fetch[0] = 8'h20; fetch[1] = 8'h08; fetch[2] = 8'h00; fetch[3] = 8'h01;
    for (int k = 0; k < 4; k++) access(0, 1'b0, 1'b1, base + 8'(k), fetch[k], q, pe, t);
    tprev = 0;
    memread[0] = 1'b1; memwrite[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      access(0, 1'b1, 1'b0, base + 8'(k), 8'h00, q, pe, t);
      chk($sformatf("fetch%0d data", k), int'(q), int'(fetch[k]));
      if (k > 0) chk($sformatf("fetch%0d spacing", k), t - tprev, 2);
      tprev = t;
    end

    // Reset during BUSY of a write on WAIT_STATES=3
    access(2, 1'b0, 1'b1, 8'h50, 8'h11, q, pe, t);
    access(2, 1'b1, 1'b0, 8'h50, 8'h00, q, pe, t);
    chk("t4 preread", int'(q), 8'h11);
    memread[2] = 1'b0; memwrite[2] = 1'b1; adr[2] = 8'h50; writedata[2] = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    #1;
    chk("t4 rst memready", int'(memready[2]), 0);
    chk("t4 rst memdata", int'(memdata[2]), 0);
    @(posedge clk); #1;
    memwrite[2] = 1'b0;
    rst_n[2] = 1'b1;
    pat = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      pat[k] = memready[2];
    end
    chk("t4 no memready after reset", int'(pat), 0);
    access(2, 1'b1, 1'b0, 8'h50, 8'h00, q, pe, t);
    chk("t4 old contents", int'(q), 8'h11);

    // Request held through DONE: one completion per IDLE sample
    hold(1, 8'h40, 8, pat);
    chk("t6 pattern ws1", int'(pat), 16'h0092);
    hold(0, 8'h40, 8, pat);
    chk("t6 pattern ws0", int'(pat), 16'h0055);

`ifdef MEMRESP_PROTECT_EN
    access(1, 1'b1, 1'b0, 8'h20, 8'h00, v0, pe, t);
    access(1, 1'b0, 1'b1, 8'h20, 8'hFF, q, pe, t);
    chk("t5 prot_err low addr", int'(pe), 1);
    access(1, 1'b1, 1'b0, 8'h20, 8'h00, q, pe, t);
    chk("t5 protected unchanged", int'(q), int'(v0));
    access(1, 1'b0, 1'b1, 8'h40, 8'hFF, q, pe, t);
    chk("t5 prot_err at limit", int'(pe), 0);
    access(1, 1'b1, 1'b0, 8'h40, 8'h00, q, pe, t);
    chk("t5 stored at limit", int'(q), 8'hFF);
`else
    access(1, 1'b0, 1'b1, 8'h20, 8'hFF, q, pe, t);
    chk("t5 prot_err tied", int'(pe), 0);
    access(1, 1'b1, 1'b0, 8'h20, 8'h00, q, pe, t);
    chk("t5 low addr writable", int'(q), 8'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
